// File: rtl/fifo_stream_reader.sv
// Read-side stream adapter for the synchronous FIFO: hides the 1-cycle read latency
// behind a 2-entry buffer. Optional stall counter enabled by FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [0:0] ST_STREAM = 1'b0;
  localparam logic [0:0] ST_FLUSH  = 1'b1;

  logic [0:0]            state;
  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;

  logic       pop;
  logic       capture;
  logic       flush_start;
  logic       drain_done;
  logic [2:0] pending;

  assign m_valid     = (occ != 2'd0);
  assign m_data      = buf_head;
  assign pop         = m_valid && m_ready;
  assign flush_start = (state == ST_STREAM) && flush;
  assign drain_done  = (state == ST_FLUSH) && fifo_empty && !inflight;
  assign capture     = inflight && (state == ST_STREAM) && !flush;
  assign pending     = {1'b0, occ} + {2'b00, inflight};
  assign flush_done  = drain_done;
  assign busy        = (state == ST_FLUSH) || (occ != 2'd0) || inflight;

  // Only request a word when the buffer is guaranteed a free slot on its arrival;
  // during reset the request is held low even though the FIFO may still look non-empty.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (rst_n && !fifo_empty) begin
      if (state == ST_FLUSH) begin
        fifo_rd_en = 1'b1;
      end else begin
        fifo_rd_en = (pending < (3'd2 + {2'b00, pop}));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_STREAM;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (flush_start) begin
        state <= ST_FLUSH;
      end else if (drain_done) begin
        state <= ST_STREAM;
      end
    end
  end

  // Two-entry buffer: head is what downstream sees, tail only holds a second word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
    end else if (flush_start) begin
      occ <= 2'd0;
    end else begin
      case ({capture, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            buf_head <= fifo_rd_data;
          end else begin
            buf_tail <= fifo_rd_data;
          end
          if (occ != 2'd2) begin
            occ <= occ + 2'd1;
          end
        end
        2'b01: begin
          buf_head <= buf_tail;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf_head <= fifo_rd_data;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= fifo_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 1'b1;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [CNT_WIDTH-1:0] stall_q;

  // Saturating count of back-pressured cycles, restarted when a flush completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (drain_done) begin
      stall_q <= '0;
    end else if (m_valid && !m_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized self-checking bench for fifo_stream_reader: a queue-based FIFO drives the
// reader and a word-level scoreboard predicts the stream, counters and flush handshake.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          flush;
  logic          flush_done;
  logic          busy;
  logic [CW-1:0] word_count;
  logic [CW-1:0] stall_count;

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .flush(flush), .flush_done(flush_done), .busy(busy), .word_count(word_count),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] m_q[$];
  bit m_inflight;
  bit m_flushing;
  int m_count;
  int m_stall;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int expStall();
`ifdef FIFO_STREAM_READER_STATS_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  // One clock cycle: drive inputs at the falling edge, compare against the model,
  // advance the model, then let the FIFO answer any read after the rising edge.
  task automatic applyStimulus(input bit ready, input bit fl, input int npush);
    bit exp_valid, exp_rd, exp_done, exp_busy, pop, rd;
    @(negedge clk);
    m_ready = ready;
    flush   = fl;
    for (int i = 0; i < npush; i++) fq.push_back(DW'($urandom));
    fifo_empty = (fq.size() == 0);
    #1;
    exp_valid = (m_q.size() != 0);
    pop       = exp_valid && ready;
    if (m_flushing) exp_rd = !fifo_empty;
    else exp_rd = !fifo_empty && ((int'(m_q.size()) + int'(m_inflight) - int'(pop)) < 2);
    exp_done = m_flushing && fifo_empty && !m_inflight;
    exp_busy = m_flushing || exp_valid || m_inflight;

    checkOutput("m_valid", m_valid, exp_valid);
    checkOutput("fifo_rd_en", fifo_rd_en, exp_rd);
    checkOutput("flush_done", flush_done, exp_done);
    checkOutput("busy", busy, exp_busy);
    checkOutput("word_count", word_count, 32'(m_count % 65536));
    checkOutput("stall_count", stall_count, 32'(expStall()));
    checkOutput("occ_le2", 32'(dut.occ <= 2'd2), 1);
    if (exp_valid) checkOutput("m_data", m_data, m_q[0]);

    if (m_flushing) begin
      if (exp_done) begin
        m_flushing = 0;
        m_stall    = 0;
      end
    end else begin
      if (exp_valid && !ready && m_stall != 65535) m_stall++;
      if (pop) begin
        void'(m_q.pop_front());
        m_count++;
      end
      if (fl) begin
        m_q.delete();
        m_flushing = 1;
      end else if (m_inflight) begin
        m_q.push_back(fifo_rd_data);
      end
    end
    m_inflight = exp_rd;
    rd = fifo_rd_en;

    @(posedge clk);
    #1;
    flush = 1'b0;
    if (rd && fq.size() > 0) fifo_rd_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic modelReset();
    fq.delete();
    m_q.delete();
    m_inflight = 0;
    m_flushing = 0;
    m_count    = 0;
    m_stall    = 0;
    fifo_empty = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rd_en"}, fifo_rd_en, 0);
    checkOutput({tag, "_m_valid"}, m_valid, 0);
    checkOutput({tag, "_m_data"}, m_data, 0);
    checkOutput({tag, "_flush_done"}, flush_done, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_word_count"}, word_count, 0);
    checkOutput({tag, "_stall_count"}, stall_count, 0);
  endtask

  int base;

  initial begin
    rst_n        = 1'b0;
    m_ready      = 1'b0;
    flush        = 1'b0;
    fifo_rd_data = '0;
    modelReset();
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Preloaded FIFO, downstream always ready.
    applyStimulus(1, 0, 3);
    for (int c = 1; c < 6; c++) applyStimulus(1, 0, 0);
    checkOutput("t1_word_count", word_count, 3);
    checkOutput("t1_m_valid_idle", m_valid, 0);

    // Back-pressure with 4 queued words, then release.
    applyStimulus(0, 0, 4);
    for (int c = 0; c < 5; c++) applyStimulus(0, 0, 0);
    checkOutput("t2_fifo_left", fq.size(), 2);
    for (int c = 0; c < 8; c++) applyStimulus(1, 0, 0);
    checkOutput("t2_word_count", word_count, 7);

    // Alternating ready over 8 words.
    base = m_count;
    for (int c = 0; c < 30; c++) applyStimulus(c[0] == 1'b0, 0, (c < 8) ? 1 : 0);
    checkOutput("t3_words", 32'(m_count - base), 8);
    checkOutput("t3_word_count", word_count, 15);

    // Flush with one word delivered and the rest buffered or still in the FIFO.
    base = m_count;
    applyStimulus(0, 0, 5);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("t4_m_valid_after_flush", m_valid, 0);
    for (int c = 0; c < 12; c++) applyStimulus(1, 0, 0);
    checkOutput("t4_word_count", word_count, 32'(base + 1));
    checkOutput("t4_fifo_drained", fq.size(), 0);

    // Flush with nothing pending.
    applyStimulus(1, 1, 0);
    checkOutput("t5_flush_done", flush_done, 1);
    applyStimulus(1, 0, 0);

    // Asynchronous reset in the middle of streaming.
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 2);
    applyStimulus(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkResetOutputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) applyStimulus(1, 0, 0);

    // Back-pressured valid for 10 cycles.
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0);
`ifdef FIFO_STREAM_READER_STATS_EN
    checkOutput("stall10", stall_count, 10);
`else
    checkOutput("stall10", stall_count, 0);
`endif
    applyStimulus(1, 0, 0);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0);
    end
    for (int c = 0; c < 60; c++) applyStimulus(1, 0, 0);
    checkOutput("final_idle_valid", m_valid, 0);
    checkOutput("final_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
